// File: rtl/gate_response_checker.sv
// Response checker for two-input gate labs. Watches the applied vector {a,b}
// and the gate output c. Once the vector has been stable for SETTLE cycles it
// samples c exactly once against the TRUTH table. Mismatches and vector
// coverage accumulate until reset.
module gate_response_checker #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             sample_valid,
  output logic             mismatch,
  output logic [1:0]       last_vec,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       covered,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  // Counter value on the last stable cycle before a sample is taken.
  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [1:0] vec;
  logic [1:0] vec_q;
  logic       vec_changed;
  logic       settle_done;
  logic       c_wrong;

  assign vec         = {a, b};
  assign vec_changed = (vec != vec_q);
  assign settle_done = (cnt_q == CntLast);
  assign c_wrong     = (c != TRUTH[vec]);

  // Vector tracking, settle FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      vec_q        <= '0;
      sample_valid <= 1'b0;
      mismatch     <= 1'b0;
      last_vec     <= '0;
      err_count    <= '0;
      covered      <= '0;
      done         <= 1'b0;
    end else begin
      vec_q        <= vec;
      sample_valid <= 1'b0;
      mismatch     <= 1'b0;
      // Registered from the previous coverage, so done trails covered by a cycle.
      done         <= &covered;
      if (!enable) begin
        // Disable wins over everything; results so far are kept.
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
          StSettle: begin
            if (vec_changed) begin
              cnt_q <= '0;
            end else if (settle_done) begin
              state_q       <= StHold;
              sample_valid  <= 1'b1;
              mismatch      <= c_wrong;
              last_vec      <= vec;
              covered[vec]  <= 1'b1;
              if (c_wrong && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          StHold: begin
            // One sample per applied vector; wait for the stimulus to move on.
            if (vec_changed) begin
              state_q <= StSettle;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (default ERR_W with a
// selectable gate model, and ERR_W=2 fed an always-wrong c), a cycle-level
// reference model that pushes expected samples, and a monitor that pops them.
module tb_gate_response_checker;

  localparam logic [3:0] Truth  = 4'b1000;
  localparam int         Settle = 4;

  typedef struct {
    int         cyc;
    logic       mm;
    logic [1:0] vec;
    int         err;
    logic [3:0] cov;
    logic       done;
  } exp_t;

  logic       clk, rst, enable, a, b, c, c_sat;
  logic       sv0, mm0, dn0, sv1, mm1, dn1;
  logic [1:0] lv0, lv1, ec1;
  logic [7:0] ec0;
  logic [3:0] cov0, cov1;
  logic [3:0] truth_tbl = Truth;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int run_len = 0;
  logic prev_active = 1'b0;
  logic [1:0] prev_vec = 2'b00;
  logic [1:0] mv;
  logic       cin, mmx;
  logic       nd [2];
  int         m_err [2];
  logic [3:0] m_cov [2];
  logic [1:0] m_last [2];
  logic       m_done [2];
  int         err_max [2] = '{255, 3};
  int         pulses [2] = '{0, 0};
  int         mm_pulses [2] = '{0, 0};
  int         last_pulse_cyc [2] = '{0, 0};
  exp_t       q0 [$];
  exp_t       q1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign c_sat = ~truth_tbl[{a, b}];

  gate_response_checker #(.TRUTH(Truth), .SETTLE(Settle), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .c(c),
    .sample_valid(sv0), .mismatch(mm0), .last_vec(lv0), .err_count(ec0),
    .covered(cov0), .done(dn0)
  );

  gate_response_checker #(.TRUTH(Truth), .SETTLE(Settle), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .c(c_sat),
    .sample_valid(sv1), .mismatch(mm1), .last_vec(lv1), .err_count(ec1),
    .covered(cov1), .done(dn1)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Gate under test for the default instance: 0 AND, 1 OR, otherwise random.
  function automatic logic uut_out(input logic [1:0] v);
    case (mode)
      0:       return v[1] & v[0];
      1:       return v[1] | v[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic int qsz(input int i);
    if (i == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qfront(input int i);
    if (i == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpop(input int i, output exp_t e);
    if (i == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  // Reference model: a sample is due when the vector has been unchanged with
  // enable high (and rst low) for Settle+1 consecutive cycles.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0; m_cov[i] = '0; m_last[i] = '0; m_done[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          m_err[i] = 0; m_cov[i] = '0; m_last[i] = '0; m_done[i] = 1'b0;
        end
        prev_active = 1'b0;
        run_len = 0;
      end else begin
        mv = {a, b};
        for (int i = 0; i < 2; i++) nd[i] = &m_cov[i];
        if (!enable) begin
          prev_active = 1'b0;
          run_len = 0;
        end else begin
          if (!prev_active || mv != prev_vec) run_len = 1;
          else run_len++;
          prev_active = 1'b1;
          if (run_len == Settle + 1) begin
            for (int i = 0; i < 2; i++) begin
              exp_t e;
              cin = (i == 0) ? c : c_sat;
              mmx = (cin != truth_tbl[mv]);
              if (mmx && m_err[i] < err_max[i]) m_err[i]++;
              m_cov[i][mv] = 1'b1;
              m_last[i] = mv;
              e.cyc = cyc; e.mm = mmx; e.vec = mv; e.err = m_err[i];
              e.cov = m_cov[i]; e.done = nd[i];
              if (i == 0) q0.push_back(e);
              else q1.push_back(e);
            end
          end
        end
        prev_vec = mv;
        for (int i = 0; i < 2; i++) m_done[i] = nd[i];
      end
    end
  end

  task automatic mon(input int i, input logic sv, input logic mm, input logic [1:0] lv,
                     input logic [31:0] ec, input logic [3:0] cov, input logic dn);
    exp_t  e;
    string p;
    p = (i == 0) ? "dflt" : "sat";
    if (sv) begin
      pulses[i]++;
      if (mm) mm_pulses[i]++;
      last_pulse_cyc[i] = cyc;
      if (qsz(i) == 0) begin
        check({p, "_unexpected_sample_valid"}, 32'(sv), 32'd0);
      end else begin
        qpop(i, e);
        check({p, "_sample_cycle"}, cyc, e.cyc);
        check({p, "_sample_mismatch"}, 32'(mm), 32'(e.mm));
        check({p, "_sample_last_vec"}, 32'(lv), 32'(e.vec));
        check({p, "_sample_err_count"}, ec, e.err);
        check({p, "_sample_covered"}, 32'(cov), 32'(e.cov));
        check({p, "_sample_done"}, 32'(dn), 32'(e.done));
      end
    end else begin
      check({p, "_mismatch_without_sample"}, 32'(mm), 32'd0);
    end
    while (qsz(i) > 0 && qfront(i).cyc < cyc) begin
      qpop(i, e);
      check({p, "_sample_missing_at_cycle"}, cyc, e.cyc);
    end
    check({p, "_err_count"}, ec, m_err[i]);
    check({p, "_covered"}, 32'(cov), 32'(m_cov[i]));
    check({p, "_last_vec"}, 32'(lv), 32'(m_last[i]));
    check({p, "_done"}, 32'(dn), 32'(m_done[i]));
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        mon(0, sv0, mm0, lv0, 32'(ec0), cov0, dn0);
        mon(1, sv1, mm1, lv1, 32'(ec1), cov1, dn1);
      end
    end
  end

  task automatic tick(input logic [1:0] v, input logic en);
    @(negedge clk);
    a = v[1];
    b = v[0];
    enable = en;
    c = uut_out(v);
  endtask

  task automatic hold(input logic [1:0] v, input logic en, input int n);
    repeat (n) tick(v, en);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dflt_sample_valid"}, 32'(sv0), 0);
    check({tag, "_dflt_mismatch"}, 32'(mm0), 0);
    check({tag, "_dflt_last_vec"}, 32'(lv0), 0);
    check({tag, "_dflt_err_count"}, 32'(ec0), 0);
    check({tag, "_dflt_covered"}, 32'(cov0), 0);
    check({tag, "_dflt_done"}, 32'(dn0), 0);
    check({tag, "_sat_sample_valid"}, 32'(sv1), 0);
    check({tag, "_sat_mismatch"}, 32'(mm1), 0);
    check({tag, "_sat_last_vec"}, 32'(lv1), 0);
    check({tag, "_sat_err_count"}, 32'(ec1), 0);
    check({tag, "_sat_covered"}, 32'(cov1), 0);
    check({tag, "_sat_done"}, 32'(dn1), 0);
  endtask

  task automatic sweep();
    hold(2'b00, 1'b1, 40);
    hold(2'b01, 1'b1, 40);
    hold(2'b10, 1'b1, 40);
    hold(2'b11, 1'b1, 40);
  endtask

  int base0, base1, mbase0, en_cyc;

  initial begin
    rst = 1'b1; enable = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Correct AND gate over the full sweep.
    mode = 0; base0 = pulses[0]; mbase0 = mm_pulses[0];
    sweep(); sync();
    check("t1_pulses", pulses[0] - base0, 4);
    check("t1_mismatch_pulses", mm_pulses[0] - mbase0, 0);
    check("t1_err_count", 32'(ec0), 0);
    check("t1_covered", 32'(cov0), 4'b1111);
    check("t1_done", 32'(dn0), 1);
    check("t1_sat_err_count", 32'(ec1), 3);

    // OR gate in place of AND: only 01 and 10 disagree.
    pulse_reset(2);
    mode = 1; base0 = pulses[0]; mbase0 = mm_pulses[0];
    sweep(); sync();
    check("t2_pulses", pulses[0] - base0, 4);
    check("t2_mismatch_pulses", mm_pulses[0] - mbase0, 2);
    check("t2_err_count", 32'(ec0), 2);
    check("t2_covered", 32'(cov0), 4'b1111);
    check("t2_done", 32'(dn0), 1);

    // Glitching stimulus never settles.
    pulse_reset(2);
    mode = 0; base0 = pulses[0];
    for (int s = 0; s < 20; s++) hold((s % 2 == 0) ? 2'b00 : 2'b11, 1'b1, 3);
    sync();
    check("t3_pulses", pulses[0] - base0, 0);
    check("t3_err_count", 32'(ec0), 0);
    check("t3_covered", 32'(cov0), 0);

    // Long hold with c wandering: one sample only.
    pulse_reset(2);
    mode = 2; base0 = pulses[0];
    hold(2'b11, 1'b1, 200); sync();
    check("t4_pulses", pulses[0] - base0, 1);
    check("t4_covered", 32'(cov0), 4'b1000);
    check("t4_done", 32'(dn0), 0);

    // Enable dropped mid-settle, raised again with the same vector.
    pulse_reset(2);
    mode = 1; base0 = pulses[0];
    hold(2'b10, 1'b1, 20);
    hold(2'b01, 1'b1, 3);
    hold(2'b01, 1'b0, 10); sync();
    check("t5_pulses_before_reenable", pulses[0] - base0, 1);
    check("t5_err_retained", 32'(ec0), 1);
    check("t5_covered_retained", 32'(cov0), 4'b0100);
    tick(2'b01, 1'b1);
    en_cyc = cyc;
    hold(2'b01, 1'b1, 20); sync();
    check("t5_reenable_latency", last_pulse_cyc[0] - en_cyc, 5);
    check("t5_pulses", pulses[0] - base0, 2);
    check("t5_err_count", 32'(ec0), 2);
    check("t5_covered", 32'(cov0), 4'b0110);

    // Saturating error count, then reset on the would-be sample edge.
    pulse_reset(2);
    mode = 0; base1 = pulses[1];
    for (int s = 0; s < 5; s++) hold((s % 2 == 0) ? 2'b00 : 2'b11, 1'b1, 10);
    sync();
    check("t6_sat_pulses", pulses[1] - base1, 5);
    check("t6_sat_err_count", 32'(ec1), 3);
    check("t6_dflt_err_count", 32'(ec0), 0);
    base1 = pulses[1];
    hold(2'b01, 1'b1, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("t6_reset");
    check("t6_discarded_sample", pulses[1] - base1, 0);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int s = 0; s < 150; s++) begin
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 39) == 0) pulse_reset(1);
      hold(2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0), $urandom_range(1, 10));
    end

    hold(2'b00, 1'b0, 8); sync();
    check("pending_samples_dflt", qsz(0), 0);
    check("pending_samples_sat", qsz(1), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
